divu_x6y3: RTL and testbench

DIVU_X6Y3 -- requirements
Module: divu_x6y3

---
 rtl/divu_x6y3.sv | 106 ++++++++++
 tb/tb_divu_x6y3.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/divu_x6y3.sv
// Sequential unsigned divider: restoring division, one quotient bit per clock,
// MSB first. Divide-by-zero finishes in one clock with q=all ones and dz set.
module divu_x6y3 #(
    parameter int P_WIDTH = 6,
    parameter int Y_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [P_WIDTH-1:0] p,
    input  logic [Y_WIDTH-1:0] y,
    output logic [P_WIDTH-1:0] q,
    output logic [Y_WIDTH-1:0] r,
    output logic               busy,
    output logic               rdy,
    output logic               dz
);

    localparam int CNT_W = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(P_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [P_WIDTH-1:0]       quo_q, quo_d;
    logic [Y_WIDTH:0]         rem_q, rem_d;
    logic [Y_WIDTH-1:0]       y_q, y_d;
    logic                     dz_q, dz_d;

    logic        [Y_WIDTH+1:0] shift;
    logic signed [Y_WIDTH+1:0] diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            y_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            y_q     <= y_d;
            dz_q    <= dz_d;
        end
    end

    // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        y_d     = y_q;
        dz_d    = dz_q;
        shift   = {rem_q, quo_q[P_WIDTH-1]};
        diff    = $signed(shift) - $signed({2'b00, y_q});

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    y_d  = y;
                    dz_d = 1'b0;
                    if (y == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = '0;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        quo_d   = p;
                        rem_d   = '0;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            RUN: begin
                if (diff[Y_WIDTH+1]) begin
                    rem_d = shift[Y_WIDTH:0];
                    quo_d = {quo_q[P_WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = diff[Y_WIDTH:0];
                    quo_d = {quo_q[P_WIDTH-2:0], 1'b1};
                end
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign q    = quo_q;
    assign r    = rem_q[Y_WIDTH-1:0];
    assign busy = (state_q == RUN);
    assign rdy  = (state_q == DONE);
    assign dz   = dz_q;

endmodule

// File: tb/tb_divu_x6y3.sv
// Self-checking bench for divu_x6y3: directed cases, random operands with
// ignored-start noise, mid-run reset and an exhaustive sweep vs. plain / and %.
module tb_divu_x6y3;

    localparam int PW = 6;
    localparam int YW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] p = '0;
    logic [YW-1:0] y = '0;
    logic [PW-1:0] q;
    logic [YW-1:0] r;
    logic          busy, rdy, dz;

    int checks   = 0;
    int failures = 0;

    divu_x6y3 #(.P_WIDTH(PW), .Y_WIDTH(YW)) dut (
        .clk(clk), .rst(rst), .start(start), .p(p), .y(y),
        .q(q), .r(r), .busy(busy), .rdy(rdy), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one division; start is held for 'hold' further edges with junk
    // operands (must be ignored). Called at posedge+1.
    task automatic do_div(input int pv, input int yv, input int hold, input bit hold_chk);
        int exp_q, exp_r, exp_dz, exp_lat;
        int lat, busy_cnt;
        logic [PW-1:0] q_s;
        logic [YW-1:0] r_s;
        if (yv == 0) begin
            exp_q = (1 << PW) - 1; exp_r = 0; exp_dz = 1; exp_lat = 0;
        end else begin
            exp_q = pv / yv; exp_r = pv % yv; exp_dz = 0; exp_lat = PW;
        end
        start = 1'b1;
        p = PW'(pv);
        y = YW'(yv);
        tick();
        p = PW'($urandom);
        y = YW'($urandom);
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        if (yv != 0) chk("rdy_clr", {31'd0, rdy}, 0);
        while (!rdy && lat < 20) begin
            if (busy) busy_cnt++;
            start = (lat + 1 <= hold) ? 1'b1 : 1'b0;
            p = PW'($urandom);
            y = YW'($urandom);
            tick();
            lat++;
        end
        start = 1'b0;
        chk("latency", lat, exp_lat);
        chk("busy_clks", busy_cnt, exp_lat);
        chk("rdy", {31'd0, rdy}, 1);
        chk("busy_done", {31'd0, busy}, 0);
        chk("q", {26'd0, q}, exp_q);
        chk("r", {29'd0, r}, exp_r);
        chk("dz", {31'd0, dz}, exp_dz);
        if (yv != 0) chk("identity", q * yv + r, pv);
        if (hold_chk) begin
            q_s = q;
            r_s = r;
            repeat (2) begin
                p = PW'($urandom);
                y = YW'($urandom);
                tick();
            end
            chk("hold_q", {26'd0, q}, {26'd0, q_s});
            chk("hold_r", {29'd0, r}, {29'd0, r_s});
            chk("hold_rdy", {31'd0, rdy}, 1);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", {26'd0, q}, 0);
        chk("rst_r", {29'd0, r}, 0);
        chk("rst_flags", {29'd0, busy, rdy, dz}, 0);
        rst = 1'b0;

        do_div(63, 7, 0, 1'b1);
        do_div(42, 5, 0, 1'b1);
        do_div(5, 7, 0, 1'b0);
        do_div(63, 1, 0, 1'b0);
        do_div(17, 0, 0, 1'b1);
        do_div(42, 5, 5, 1'b0);
        do_div(63, 7, 0, 1'b0);
        do_div(50, 3, PW, 1'b0);
        do_div(0, 6, 0, 1'b0);

        // Abort mid-run: reset asserted between edges must clear outputs at once.
        start = 1'b1; p = 6'd63; y = 3'd7;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_q", {26'd0, q}, 0);
        chk("abort_r", {29'd0, r}, 0);
        chk("abort_flags", {29'd0, busy, rdy, dz}, 0);
        #1 rst = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (10) begin
                tick();
                if (rdy || busy) seen++;
            end
            chk("abort_no_rdy", seen, 0);
        end
        do_div(10, 3, 0, 1'b0);

        repeat (30) begin
            int pv, yv, hv;
            pv = int'($urandom_range(0, (1 << PW) - 1));
            yv = int'($urandom_range(0, (1 << YW) - 1));
            hv = int'($urandom_range(0, PW));
            do_div(pv, yv, hv, 1'b0);
        end

        for (int pv = 0; pv < (1 << PW); pv++) begin
            for (int yv = 1; yv < (1 << YW); yv++) begin
                do_div(pv, yv, 0, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
